// File: rtl/periph_buttons.sv
// periph_buttons: iobus input peripheral that synchronises, debounces and latches button events.
// Define BUTTONS_RELEASE_EVT_EN to add the RELEASE event register at 0x03.
module periph_buttons #(
  parameter int PERIPH_DATA_WIDTH = 32,
  parameter int PERIPH_ADDR_WIDTH = 8,
  parameter int NUM_BUTTONS = 8,
  parameter int DEBOUNCE_W = 16,
  parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_DEFAULT = 16'd1000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         read,
  input  logic                         write,
  input  logic [PERIPH_ADDR_WIDTH-1:0] addr,
  inout  wire  [PERIPH_DATA_WIDTH-1:0] data,
  output logic                         ready,
  input  logic [NUM_BUTTONS-1:0]       buttons
);

  localparam logic [PERIPH_ADDR_WIDTH-1:0] A_STATE   = PERIPH_ADDR_WIDTH'(0);
  localparam logic [PERIPH_ADDR_WIDTH-1:0] A_PRESS   = PERIPH_ADDR_WIDTH'(1);
  localparam logic [PERIPH_ADDR_WIDTH-1:0] A_LIMIT   = PERIPH_ADDR_WIDTH'(2);
  localparam logic [DEBOUNCE_W-1:0]        CNT_ONE   = DEBOUNCE_W'(1);

  typedef enum logic {IDLE, ACK} bus_st_t;

  bus_st_t                      bus_st;
  logic [NUM_BUTTONS-1:0]       sync_p0, sync_p1;
  logic [NUM_BUTTONS-1:0]       state_q, state_nxt, rise;
  logic [NUM_BUTTONS-1:0]       press_q, press_clr;
  logic [DEBOUNCE_W-1:0]        cnt_q [NUM_BUTTONS];
  logic [DEBOUNCE_W-1:0]        limit_q, cnt_term;
  logic [PERIPH_DATA_WIDTH-1:0] rdata_q, rd_mux;
  logic                         drive_q, req, acc_rd, acc_wr, sel_press;
  logic                         unused_data;

  function automatic logic [PERIPH_DATA_WIDTH-1:0] zext_btn(input logic [NUM_BUTTONS-1:0] v);
    zext_btn = '0;
    zext_btn[NUM_BUTTONS-1:0] = v;
  endfunction

  function automatic logic [PERIPH_DATA_WIDTH-1:0] zext_lim(input logic [DEBOUNCE_W-1:0] v);
    zext_lim = '0;
    zext_lim[DEBOUNCE_W-1:0] = v;
  endfunction

  // A LIMIT of 0 behaves like 1: accept on the first mismatching cycle.
  function automatic logic [DEBOUNCE_W-1:0] term_of(input logic [DEBOUNCE_W-1:0] lim);
    term_of = (lim == '0) ? '0 : lim - CNT_ONE;
  endfunction

  assign cnt_term    = term_of(limit_q);
  assign req         = read | write;
  assign acc_wr      = (bus_st == IDLE) && write;
  assign acc_rd      = (bus_st == IDLE) && read && !write;
  assign sel_press   = (addr == A_PRESS);
  assign data        = drive_q ? rdata_q : 'z;
  assign unused_data = ^data;

  // Stage p0/p1: two-flop synchroniser feeding the debounce counters
  always_comb begin
    state_nxt = state_q;
    for (int i = 0; i < NUM_BUTTONS; i++)
      if ((sync_p1[i] != state_q[i]) && (cnt_q[i] >= cnt_term))
        state_nxt[i] = sync_p1[i];
  end

  assign rise = state_nxt & ~state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      state_q <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) cnt_q[i] <= '0;
    end else begin
      sync_p0 <= buttons;
      sync_p1 <= sync_p0;
      state_q <= state_nxt;
      for (int i = 0; i < NUM_BUTTONS; i++)
        if ((sync_p1[i] == state_q[i]) || (state_nxt[i] != state_q[i]))
          cnt_q[i] <= '0;
        else
          cnt_q[i] <= cnt_q[i] + CNT_ONE;
    end
  end

  always_comb begin
    press_clr = '0;
    if (acc_rd && sel_press)      press_clr = press_q;
    else if (acc_wr && sel_press) press_clr = data[NUM_BUTTONS-1:0];
  end

  // New edges are OR'd in after the clear so a simultaneous set survives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_q <= '0;
      limit_q <= DEBOUNCE_DEFAULT;
    end else begin
      press_q <= (press_q & ~press_clr) | rise;
      if (acc_wr && (addr == A_LIMIT)) limit_q <= data[DEBOUNCE_W-1:0];
    end
  end

`ifdef BUTTONS_RELEASE_EVT_EN
  localparam logic [PERIPH_ADDR_WIDTH-1:0] A_RELEASE = PERIPH_ADDR_WIDTH'(3);
  logic [NUM_BUTTONS-1:0] release_q, release_clr, fall;
  logic                   sel_release;

  assign fall        = state_q & ~state_nxt;
  assign sel_release = (addr == A_RELEASE);

  always_comb begin
    release_clr = '0;
    if (acc_rd && sel_release)      release_clr = release_q;
    else if (acc_wr && sel_release) release_clr = data[NUM_BUTTONS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) release_q <= '0;
    else        release_q <= (release_q & ~release_clr) | fall;
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_STATE:   rd_mux = zext_btn(state_q);
      A_PRESS:   rd_mux = zext_btn(press_q);
      A_LIMIT:   rd_mux = zext_lim(limit_q);
`ifdef BUTTONS_RELEASE_EVT_EN
      A_RELEASE: rd_mux = zext_btn(release_q);
`endif
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_st  <= IDLE;
      ready   <= 1'b0;
      drive_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (bus_st)
        IDLE: if (req) begin
          bus_st  <= ACK;
          ready   <= 1'b1;
          drive_q <= acc_rd;
          rdata_q <= acc_rd ? rd_mux : '0;
        end
        ACK: if (!req) begin
          bus_st  <= IDLE;
          ready   <= 1'b0;
          drive_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_periph_buttons.sv
// Self-checking bench for periph_buttons: vector table, directed corner sequences, random stimulus vs model.
module tb_periph_buttons;

  localparam int HIST_MAX = 1100;

  logic        clk = 1'b0;
  logic        rst_n, read, write, ready, data_oe;
  logic [7:0]  addr, buttons;
  logic [31:0] data_drv;
  wire  [31:0] data;

  assign data = data_oe ? data_drv : 'z;

  periph_buttons dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .addr(addr),
    .data(data), .ready(ready), .buttons(buttons)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: button history plus event/limit registers.
  logic [7:0]  hist[$];
  logic [7:0]  mstate, mpress, mrel;
  logic [15:0] mlimit;
  bit          m_req, m_wr;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata, m_exp;

  typedef struct {
    bit          wr;
    logic [7:0]  waddr;
    logic [31:0] wdata;
    logic [7:0]  raddr;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < HIST_MAX; i++) hist.push_back(8'h00);
    mstate = 8'h00; mpress = 8'h00; mrel = 8'h00; mlimit = 16'd1000;
    m_req = 1'b0; m_wr = 1'b0; m_addr = 8'h00; m_wdata = '0; m_exp = '0;
  endtask

  // A level is accepted once the synchronised input (two edges late) has
  // shown the opposite value for max(LIMIT,1) consecutive samples.
  task automatic model_edge();
    logic [7:0]  nst, rise, fall, pclr, rclr, hv;
    logic [15:0] nlim;
    int          lim;
    bit          run;
    hist.push_front(buttons);
    if (hist.size() > HIST_MAX) void'(hist.pop_back());
    lim = (mlimit == 16'd0) ? 1 : int'(mlimit);
    nst = mstate;
    for (int i = 0; i < 8; i++) begin
      run = 1'b1;
      for (int k = 2; k < lim + 2 && run; k++) begin
        if (k < hist.size()) hv = hist[k]; else hv = 8'h00;
        if (hv[i] == mstate[i]) run = 1'b0;
      end
      if (run) nst[i] = ~mstate[i];
    end
    rise = nst & ~mstate;
    fall = mstate & ~nst;
    pclr = 8'h00; rclr = 8'h00; nlim = mlimit;
    if (m_req) begin
      m_exp = '0;
      if (m_wr) begin
        if (m_addr == 8'h01) pclr = m_wdata[7:0];
        else if (m_addr == 8'h02) nlim = m_wdata[15:0];
`ifdef BUTTONS_RELEASE_EVT_EN
        else if (m_addr == 8'h03) rclr = m_wdata[7:0];
`endif
      end else begin
        case (m_addr)
          8'h00: m_exp = {24'h0, mstate};
          8'h01: begin m_exp = {24'h0, mpress}; pclr = mpress; end
          8'h02: m_exp = {16'h0, mlimit};
`ifdef BUTTONS_RELEASE_EVT_EN
          8'h03: begin m_exp = {24'h0, mrel}; rclr = mrel; end
`endif
          default: m_exp = '0;
        endcase
      end
      m_req = 1'b0;
    end
    mpress = (mpress & ~pclr) | rise;
    mrel   = (mrel & ~rclr) | fall;
    mstate = nst;
    mlimit = nlim;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_ne(input string name, input logic [31:0] got, input logic [31:0] notv);
    total++;
    if (got === notv) begin
      bad++;
      $display("FAIL %s: got=%h expected anything but %h (bus released)", name, got, notv);
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 16) begin tick(); n++; end
    if (!ready) begin
      total++; bad++;
      $display("FAIL %s_timeout: ready=%b expected=1", name, ready);
    end
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] got, output logic [31:0] exp);
    addr = a; read = 1'b1;
    m_req = 1'b1; m_wr = 1'b0; m_addr = a;
    tick();
    exp = m_exp;
    wait_ready("bus_rd");
    got = data;
    read = 1'b0;
    tick();
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; write = 1'b1; data_oe = 1'b1; data_drv = d;
    m_req = 1'b1; m_wr = 1'b1; m_addr = a; m_wdata = d;
    tick();
    wait_ready("bus_wr");
    write = 1'b0; data_oe = 1'b0;
    tick();
  endtask

  task automatic rd_const(input string name, input logic [7:0] a, input logic [31:0] expv);
    logic [31:0] got, mexp;
    bus_rd(a, got, mexp);
    check(name, got, expv);
  endtask

  initial begin
    logic [31:0] got, mexp;
    vecs[0] = '{1'b1, 8'h02, 32'h0000_0007, 8'h02, 32'h0000_0007};
    vecs[1] = '{1'b1, 8'h02, 32'hABCD_1234, 8'h02, 32'h0000_1234};
    vecs[2] = '{1'b1, 8'h05, 32'h0000_FFFF, 8'h05, 32'h0000_0000};
    vecs[3] = '{1'b0, 8'h00, 32'h0000_0000, 8'h02, 32'h0000_1234};
    vecs[4] = '{1'b1, 8'h00, 32'h0000_00FF, 8'h00, 32'h0000_0000};
    vecs[5] = '{1'b0, 8'h00, 32'h0000_0000, 8'h03, 32'h0000_0000};
    vecs[6] = '{1'b1, 8'hFF, 32'hFFFF_FFFF, 8'hFF, 32'h0000_0000};
    vecs[7] = '{1'b1, 8'h02, 32'h0000_0000, 8'h02, 32'h0000_0000};

    rst_n = 1'b0; read = 1'b0; write = 1'b0; addr = 8'h00;
    buttons = 8'h00; data_oe = 1'b0; data_drv = '0;
    model_reset();
    repeat (3) begin @(posedge clk); #1; end
    check("rst_ready", {31'b0, ready}, 32'd0);
    rst_n = 1'b1;

    // Handshake: read LIMIT held for cycles 0-4
    addr = 8'h02; read = 1'b1;
    m_req = 1'b1; m_wr = 1'b0; m_addr = 8'h02;
    check("hs_c0_ready", {31'b0, ready}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("hs_c%0d_ready", c), {31'b0, ready}, 32'd1);
      check($sformatf("hs_c%0d_data", c), data, 32'd1000);
    end
    tick();
    read = 1'b0;
    tick();
    check("hs_release_ready", {31'b0, ready}, 32'd0);
    check_ne("hs_release_data", data, 32'd1000);

    for (int v = 0; v < 8; v++) begin
      if (vecs[v].wr) bus_wr(vecs[v].waddr, vecs[v].wdata);
      rd_const($sformatf("vec%0d", v), vecs[v].raddr, vecs[v].exp);
    end

    bus_wr(8'h02, 32'd1000);
    buttons = 8'h05;
    repeat (1010) tick();
    rd_const("hold_state", 8'h00, 32'h5);
    rd_const("hold_press", 8'h01, 32'h5);
    rd_const("hold_press_clr", 8'h01, 32'h0);

    bus_wr(8'h02, 32'd4);
    buttons = 8'h0D; repeat (3) tick();
    buttons = 8'h05; repeat (12) tick();
    rd_const("glitch_state", 8'h00, 32'h5);
    rd_const("glitch_press", 8'h01, 32'h0);
    buttons = 8'h0D; repeat (6) tick();
    buttons = 8'h05; repeat (2) tick();
    rd_const("pulse6_state", 8'h00, 32'hD);
    rd_const("pulse6_press", 8'h01, 32'h8);

    buttons = 8'h00; repeat (20) tick();
    bus_rd(8'h01, got, mexp);

    // Read and write together: write wins, bus never driven by DUT
    addr = 8'h02; read = 1'b1; write = 1'b1; data_oe = 1'b1; data_drv = 32'h10;
    m_req = 1'b1; m_wr = 1'b1; m_addr = 8'h02; m_wdata = 32'h10;
    for (int c = 1; c <= 2; c++) begin
      tick();
      check($sformatf("rw_c%0d_ready", c), {31'b0, ready}, 32'd1);
      check($sformatf("rw_c%0d_data", c), data, 32'h10);
    end
    read = 1'b0; write = 1'b0; data_oe = 1'b0;
    tick();
    check("rw_done_ready", {31'b0, ready}, 32'd0);
    rd_const("rw_limit", 8'h02, 32'd16);

    // Press edge landing on the PRESS read capture edge
    bus_wr(8'h02, 32'd3);
    buttons = 8'h01; repeat (4) tick();
    rd_const("setwin_rd_now", 8'h01, 32'h0);
    rd_const("setwin_rd_next", 8'h01, 32'h1);
    buttons = 8'h00; repeat (10) tick();
    buttons = 8'h01; repeat (4) tick();
    bus_wr(8'h01, 32'h1);
    rd_const("setwin_w1c_next", 8'h01, 32'h1);

    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 2) == 0) buttons = buttons ^ (8'h01 << $urandom_range(0, 7));
      tick();
      if (it % 16 == 15) begin
        bus_rd(8'($urandom_range(0, 3)), got, mexp);
        check($sformatf("rand_rd_%0d", it), got, mexp);
      end
      if (it % 50 == 49) bus_wr(8'h01, $urandom);
    end

    // Reset while in ACK
    buttons = 8'h00;
    repeat (10) tick();
    addr = 8'h02; read = 1'b1;
    m_req = 1'b1; m_wr = 1'b0; m_addr = 8'h02;
    tick();
    check("ack_ready", {31'b0, ready}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {31'b0, ready}, 32'd0);
    check_ne("midrst_data", data, 32'd3);
    read = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    rd_const("midrst_limit", 8'h02, 32'd1000);

    bus_wr(8'h02, 32'd2);
    buttons = 8'h01; repeat (10) tick();
    bus_rd(8'h03, got, mexp);
    bus_rd(8'h01, got, mexp);
    buttons = 8'h00; repeat (10) tick();
`ifdef BUTTONS_RELEASE_EVT_EN
    rd_const("release_evt", 8'h03, 32'h1);
`else
    rd_const("release_unmapped", 8'h03, 32'h0);
`endif
    rd_const("release_clr", 8'h03, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
